// File: rtl/rr_arb_pkg.sv
// Shared defaults, arbitration mode encodings and a small modular helper
// for the round-robin FIFO arbiter.
package rr_arb_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;

    localparam int ARB_STRICT          = 0;
    localparam int ARB_WORK_CONSERVING = 1;

    // Increment modulo n without a divider.
    function automatic int wrap_inc(input int v, input int n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data; a write into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    // Status flags and accepted push/pop strobes.
    always_comb begin
        full   = (count_r == FULL_CNT);
        empty  = (count_r == {(AW + 1){1'b0}});
        push_s = wen & (~full | ren);
        pop_s  = ren & ~empty;
        rdata  = mem_r[rd_ptr_r];
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (push_s && rst_n) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rr_fifo_arbiter_n.sv
// N-channel round-robin arbiter draining per-channel FIFOs into one
// registered valid/ready output port, with strict or work-conserving rotation.
module rr_fifo_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int N_CH            = N_CH_DEF,
    parameter int WIDTH           = WIDTH_DEF,
    parameter int DEPTH           = DEPTH_DEF,
    parameter int WORK_CONSERVING = ARB_WORK_CONSERVING,
    localparam int CH_W           = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       wen,
    input  logic [N_CH*WIDTH-1:0] din,
    output logic [N_CH-1:0]       full,
    output logic [N_CH-1:0]       ovf,
    input  logic                  ready,
    output logic                  valid,
    output logic [WIDTH-1:0]      dout,
    output logic [CH_W-1:0]       dout_ch
);

    logic [N_CH-1:0]  empty_s;
    logic [N_CH-1:0]  full_s;
    logic [N_CH-1:0]  pop_s;
    logic [WIDTH-1:0] rdata_s [N_CH];
    logic [CH_W-1:0]  ptr_r;
    logic [CH_W-1:0]  ptr_nxt_s;
    logic [CH_W-1:0]  sel_s;
    logic [CH_W-1:0]  cand_s;
    logic             found_s;
    logic             adv_s;
    logic             valid_r;
    logic [WIDTH-1:0] dout_r;
    logic [CH_W-1:0]  dout_ch_r;
    logic [N_CH-1:0]  ovf_r;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sync_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .wen  (wen[i]),
            .ren  (pop_s[i]),
            .din  (din[i*WIDTH +: WIDTH]),
            .rdata(rdata_s[i]),
            .full (full_s[i]),
            .empty(empty_s[i])
        );
    end

    // Rotating-priority grant search and next grant pointer.
    always_comb begin
        adv_s   = ~valid_r | ready;
        found_s = 1'b0;
        sel_s   = ptr_r;
        cand_s  = ptr_r;
        if (WORK_CONSERVING == ARB_WORK_CONSERVING) begin
            // Walk from the farthest candidate back to ptr so the nearest wins.
            for (int k = N_CH - 1; k >= 0; k--) begin
                cand_s  = CH_W'((int'(ptr_r) + k) % N_CH);
                sel_s   = empty_s[cand_s] ? sel_s : cand_s;
                found_s = found_s | ~empty_s[cand_s];
            end
            ptr_nxt_s = (adv_s && found_s) ? CH_W'(wrap_inc(int'(sel_s), N_CH)) : ptr_r;
        end else begin
            found_s   = ~empty_s[ptr_r];
            ptr_nxt_s = adv_s ? CH_W'(wrap_inc(int'(ptr_r), N_CH)) : ptr_r;
        end
    end

    // One-hot pop toward the granted FIFO.
    always_comb begin
        pop_s = {N_CH{1'b0}};
        if (adv_s && found_s) begin
            pop_s[sel_s] = 1'b1;
        end else begin
            pop_s = {N_CH{1'b0}};
        end
    end

    // Output register, grant pointer and overflow pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            dout_r    <= {WIDTH{1'b0}};
            dout_ch_r <= {CH_W{1'b0}};
            ptr_r     <= {CH_W{1'b0}};
            ovf_r     <= {N_CH{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
            ovf_r <= wen & full_s & ~pop_s;
            if (adv_s) begin
                valid_r <= found_s;
                if (found_s) begin
                    dout_r    <= rdata_s[sel_s];
                    dout_ch_r <= sel_s;
                end
            end
        end
    end

    assign full    = full_s;
    assign ovf     = ovf_r;
    assign valid   = valid_r;
    assign dout    = dout_r;
    assign dout_ch = dout_ch_r;

endmodule

// File: tb/tb_rr_fifo_arbiter_n.sv
// Drives a strict (index 0) and a work-conserving (index 1) arbiter with the
// same stimulus and compares both against queue-based reference models.
module tb_rr_fifo_arbiter_n;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  wen;
    logic [N*W-1:0] din;
    logic          ready;

    logic [1:0]    valid_o;
    logic [W-1:0]  dout_o    [2];
    logic [1:0]    dout_ch_o [2];
    logic [N-1:0]  full_o    [2];
    logic [N-1:0]  ovf_o     [2];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state per instance.
    logic [7:0] mq [2][N][$];
    int         mptr   [2];
    logic       mvalid [2];
    logic [7:0] mdout  [2];
    int         mch    [2];
    logic [N-1:0] movf [2];

    always #5 clk = ~clk;

    rr_fifo_arbiter_n #(.N_CH(N), .WIDTH(W), .DEPTH(D), .WORK_CONSERVING(0)) u_strict (
        .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .full(full_o[0]), .ovf(ovf_o[0]),
        .ready(ready), .valid(valid_o[0]), .dout(dout_o[0]), .dout_ch(dout_ch_o[0])
    );

    rr_fifo_arbiter_n #(.N_CH(N), .WIDTH(W), .DEPTH(D), .WORK_CONSERVING(1)) u_wc (
        .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .full(full_o[1]), .ovf(ovf_o[1]),
        .ready(ready), .valid(valid_o[1]), .dout(dout_o[1]), .dout_ch(dout_ch_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step(input int m);
        bit found;
        int sel;
        bit adv;
        int pre [N];
        if (!rst_n) begin
            for (int c = 0; c < N; c++) mq[m][c].delete();
            mvalid[m] = 1'b0; mdout[m] = 8'h00; mch[m] = 0; mptr[m] = 0; movf[m] = '0;
            return;
        end
        adv = !mvalid[m] || ready;
        found = 1'b0;
        sel = 0;
        if (adv) begin
            if (m == 1) begin
                for (int k = 0; k < N; k++) begin
                    int c = (mptr[m] + k) % N;
                    if (!found && mq[m][c].size() > 0) begin found = 1'b1; sel = c; end
                end
            end else begin
                sel = mptr[m];
                found = mq[m][sel].size() > 0;
            end
        end
        for (int c = 0; c < N; c++) pre[c] = mq[m][c].size();
        if (found) begin
            mdout[m] = mq[m][sel].pop_front();
            mch[m] = sel;
        end
        if (adv) begin
            mvalid[m] = found;
            if (m == 1) begin
                if (found) mptr[m] = (sel + 1) % N;
            end else begin
                mptr[m] = (mptr[m] + 1) % N;
            end
        end
        movf[m] = '0;
        for (int c = 0; c < N; c++) begin
            if (wen[c]) begin
                if (pre[c] < D || (found && sel == c)) mq[m][c].push_back(din[c*W +: W]);
                else movf[m][c] = 1'b1;
            end
        end
    endtask

    task automatic compare_model(input int m);
        logic [N-1:0] ef;
        for (int c = 0; c < N; c++) ef[c] = (mq[m][c].size() == D);
        chk($sformatf("valid_m%0d", m), 32'(valid_o[m]), 32'(mvalid[m]));
        if (mvalid[m]) begin
            chk($sformatf("dout_m%0d", m), 32'(dout_o[m]), 32'(mdout[m]));
            chk($sformatf("dout_ch_m%0d", m), 32'(dout_ch_o[m]), 32'(mch[m]));
        end
        chk($sformatf("full_m%0d", m), 32'(full_o[m]), 32'(ef));
        chk($sformatf("ovf_m%0d", m), 32'(ovf_o[m]), 32'(movf[m]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_model(0);
        compare_model(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wen = '0; ready = 1'b0;
        cycle();
        cycle();
        for (int m = 0; m < 2; m++) begin
            chk("rst_valid", 32'(valid_o[m]), 32'd0);
            chk("rst_dout", 32'(dout_o[m]), 32'd0);
            chk("rst_full", 32'(full_o[m]), 32'd0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] last;
        bit seen_ff;
        rst_n = 1'b0; wen = '0; din = '0; ready = 1'b0;

        // Two channels written together drain in rotation order.
        do_reset();
        ready = 1'b1; wen = 4'b1001; din = 32'h4400_0011;
        cycle();
        wen = '0;
        cycle();
        chk("tp1_d0", 32'(dout_o[1]), 32'h11); chk("tp1_c0", 32'(dout_ch_o[1]), 32'd0);
        cycle();
        chk("tp1_d1", 32'(dout_o[1]), 32'h44); chk("tp1_c1", 32'(dout_ch_o[1]), 32'd3);
        cycle();
        chk("tp1_idle", 32'(valid_o[1]), 32'd0);

        // Strict rotation: empty slots produce bubbles.
        do_reset();
        ready = 1'b1;
        repeat (3) cycle();
        wen = 4'b0100; din = 32'h005A_0000;
        cycle();
        wen = '0;
        cycle(); chk("tp2_slot0", 32'(valid_o[0]), 32'd0);
        cycle(); chk("tp2_slot1", 32'(valid_o[0]), 32'd0);
        cycle(); chk("tp2_slot2", 32'(valid_o[0]), 32'd1);
        chk("tp2_dout", 32'(dout_o[0]), 32'h5A); chk("tp2_ch", 32'(dout_ch_o[0]), 32'd2);

        // Fill channel 1 under backpressure, then overflow it.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wen = 4'b0010; din = 32'(8'h20 + 8'(i)) << 8;
            cycle();
        end
        chk("tp3_full", 32'(full_o[1][1]), 32'd1);
        wen = 4'b0010; din = 32'h0000_FF00;
        cycle();
        chk("tp3_ovf", 32'(ovf_o[1][1]), 32'd1);
        wen = '0;
        cycle();
        chk("tp3_ovf_once", 32'(ovf_o[1][1]), 32'd0);

        // Write into the full channel while it is popped.
        ready = 1'b1; wen = 4'b0010; din = 32'h0000_9900;
        cycle();
        chk("tp4_no_ovf", 32'(ovf_o[1][1]), 32'd0);
        wen = '0;
        last = 8'h00; seen_ff = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (valid_o[1]) begin
                last = dout_o[1];
                if (dout_o[1] == 8'hFF) seen_ff = 1'b1;
            end
        end
        chk("tp4_last", 32'(last), 32'h99);
        chk("tp3_no_ff", 32'(seen_ff), 32'd0);

        // Output holds under backpressure.
        do_reset();
        ready = 1'b0; wen = 4'b0101; din = 32'h0032_0031;
        cycle();
        wen = '0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("tp5_valid", 32'(valid_o[1]), 32'd1);
            chk("tp5_dout", 32'(dout_o[1]), 32'h31);
        end
        ready = 1'b1;
        cycle();
        chk("tp5_next", 32'(dout_o[1]), 32'h32);
        chk("tp5_next_ch", 32'(dout_ch_o[1]), 32'd2);

        // Reset with data in flight discards it; writes during reset ignored.
        ready = 1'b0; wen = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            din = $urandom();
            cycle();
        end
        rst_n = 1'b0;
        cycle();
        chk("tp6_valid", 32'(valid_o[1]), 32'd0);
        chk("tp6_dout", 32'(dout_o[1]), 32'd0);
        chk("tp6_full", 32'(full_o[1]), 32'd0);
        rst_n = 1'b1; ready = 1'b1; wen = 4'b1000; din = 32'h7700_0000;
        cycle();
        wen = '0;
        cycle();
        chk("tp6_new", 32'(dout_o[1]), 32'h77);
        chk("tp6_new_ch", 32'(dout_ch_o[1]), 32'd3);
        cycle();
        chk("tp6_empty", 32'(valid_o[1]), 32'd0);

        // Randomized traffic with phases of heavy backpressure.
        for (int i = 0; i < 3000; i++) begin
            int rp;
            rp = ((i / 200) % 3 == 0) ? 20 : 80;
            rst_n = ($urandom_range(0, 299) != 0);
            ready = ($urandom_range(0, 99) < rp);
            wen = N'($urandom());
            din = $urandom();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_fifo_arbiter_n.md
# rr_fifo_arbiter_n

Parametrised N-channel round-robin FIFO arbiter: each channel has its own synchronous FIFO, and one shared output port drains them in round-robin order. It extends the fixed 4×8-bit strict-rotation arbiter with configurable width, depth and channel count, a work-conserving mode, full/overflow reporting, and valid/ready backpressure on the output. It sits between independent producers and a single consumer stage.

## Interface
- N_CH, 4: number of channels; at least 2.
- WIDTH, 8: data width.
- DEPTH, 8: entries per channel FIFO; a power of 2, at least 2.
- WORK_CONSERVING, 1: 1 = skip empty channels; 0 = strict slot rotation.
- CH_W (localparam): $clog2(N_CH).
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- wen  in  N_CH  per-channel write strobe.
- din  in  N_CH*WIDTH  flattened write data; channel i occupies bits [i*WIDTH +: WIDTH].
- full  out  N_CH  per-channel FIFO full (combinational from the count).
- ovf  out  N_CH  registered one-cycle pulse: the write on that channel was dropped.
- ready  in  1  consumer accepts the current output word.
- valid  out  1  registered; dout/dout_ch hold a word.
- dout  out  WIDTH  registered output data.
- dout_ch  out  CH_W  source channel of dout.

## Operation
- Each channel FIFO has a write pointer, a read pointer (both $clog2(DEPTH) bits, wrapping naturally) and a count of $clog2(DEPTH)+1 bits.
- Output advance condition: adv = !valid || ready.
- Grant pointer ptr (CH_W bits) names the channel searched first.
- WORK_CONSERVING=1:
  - When adv is true, select the first non-empty channel starting at ptr, searching upward modulo N_CH.
  - If one is found: pop it, load dout/dout_ch, set valid=1, and set ptr = selected+1 mod N_CH.
  - If none is found: no pop, valid=0, ptr holds.
- WORK_CONSERVING=0:
  - When adv is true, ptr advances by 1 mod N_CH every cycle.
  - The slot channel is popped only if it is non-empty; otherwise valid=0 for that cycle.
- adv false (valid=1 and ready=0): no pop; dout, dout_ch, valid and ptr all hold.
- Emptiness is sampled at the start of the cycle, so a word written in cycle k is not poppable in cycle k.
- Simultaneous write and pop on the same channel:
  - Both proceed and the count is unchanged.
  - This is legal, not an error.
- Write to a full channel while that channel is popped in the same cycle: accepted.
- Write to a full channel with no pop: data dropped, pointers and count unchanged, ovf[i]=1 on the next cycle.
- A pop is never attempted on an empty channel, so there is no underflow error.
- Reset mid-operation: all FIFO contents are discarded on the reset edge; MEM is not cleared.
- Reset values: valid=0, dout=0, dout_ch=0, ovf=0, ptr=0, all counts 0 (so full=0).
- While rst_n=0, wen is ignored.

## Timing
- Write at edge k, with the output idle or ready=1: the word is on dout with valid=1 after edge k+1. Minimum latency is 1 cycle after storage.
- Throughput: one word per cycle when ready=1 and data is available.
- With WORK_CONSERVING=0, a single active channel sees at most one word every N_CH cycles.
- ovf asserts one cycle after the dropped write and lasts exactly one cycle per dropped write.
- full reflects the count after the previous edge.

## Structure
- Shared package/header rr_arb_pkg holds:
  - default WIDTH/DEPTH/N_CH;
  - mode encodings ARB_STRICT=0, ARB_WORK_CONSERVING=1.
- One sub-module, sync_fifo #(WIDTH, DEPTH):
  - ports: wen, ren, din, rdata, full, empty;
  - read data is combinational from MEM[rd_ptr];
  - instantiated N_CH times in a generate loop.
- The top level contains the grant search (rotating priority), ptr, the output register, and the ovf registers.

## Test plan
- Reset, then WORK_CONSERVING=1, N_CH=4: write A=0x11 to channel 0 and D=0x44 to channel 3 in the same cycle, ready=1 -> dout 0x11 (ch 0) on the next cycle, then 0x44 (ch 3); valid drops the following cycle.
- WORK_CONSERVING=0, only channel 2 holds 0x5A, ptr=0, ready=1 -> valid=0 for the ch 0 and ch 1 slots, then dout=0x5A, dout_ch=2 in the third cycle.
- Fill channel 1 with 8 words (DEPTH=8), ready=0 -> full[1]=1; a 9th write of 0xFF gives ovf[1]=1 for exactly one cycle, and 0xFF never appears on dout.
- Channel 1 full, ready=1, write 0x99 in the same cycle channel 1 is popped -> no ovf; 0x99 is drained last, in order.
- ready held 0 for 3 cycles with valid=1 -> dout, dout_ch and valid stable; ptr unchanged; no FIFO counts decrement.
- Assert rst_n=0 with channels half full -> next cycle valid=0, dout=0, full=0; a subsequent read returns only data written after reset.
